compressor_tree_pipe: RTL and testbench

Parametrised, pipelined carry-save reduction tree. Reduces NUM_OPS operands of WIDTH_I bits to a redundant sum/carry pair using levels of 3:2 full-adder compression. Register slices are inserted at a configurable level interval, with valid/ready flow control and flush. Serves as the mantissa-product accumulation core of the dot-product datapath, feeding the final carry-propagate adder.

---
 rtl/compressor_tree_pipe_pkg.sv | 50 +++++
 rtl/compressor_tree_pipe_csa_level.sv | 37 +++
 rtl/compressor_tree_pipe.sv | 121 ++++++++++++
 tb/tb_compressor_tree_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_tree_pipe_pkg.sv
// Shared types and constant functions for the pipelined carry-save compressor tree.
package compressor_tree_pipe_pkg;

  typedef struct packed {
    logic sum;
    logic carry;
  } fa_out_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Rows remaining after lvl levels of 3:2 compression, starting from n rows.
  function automatic int unsigned rows_after(input int unsigned n, input int unsigned lvl);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      if (r > 2) r = 2 * (r / 3) + r % 3;
    end
    return r;
  endfunction

  function automatic int unsigned num_levels(input int unsigned n);
    int unsigned r;
    int unsigned l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      l++;
    end
    return l;
  endfunction

  function automatic fa_out_t fulladder(input logic a, input logic b, input logic c);
    fa_out_t f;
    f.sum   = a ^ b ^ c;
    f.carry = (a & b) | (a & c) | (b & c);
    return f;
  endfunction

endpackage

// File: rtl/compressor_tree_pipe_csa_level.sv
// One combinational 3:2 compression level: each group of three rows becomes a sum row
// and a left-shifted carry row; leftover rows pass through after the compressed rows.
module compressor_tree_pipe_csa_level
  import compressor_tree_pipe_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic [N_IN-1:0][WIDTH-1:0]                rows_i,
  output logic [rows_after(N_IN, 1)-1:0][WIDTH-1:0] rows_o
);

  localparam int unsigned NUM_GRP  = N_IN / 3;
  localparam int unsigned NUM_LEFT = N_IN % 3;

  always_comb begin
    fa_out_t fa;
    logic    cy;
    rows_o = '0;
    fa     = '0;
    cy     = 1'b0;
    for (int g = 0; g < int'(NUM_GRP); g++) begin
      cy = 1'b0;
      // Carry out of bit b lands at bit b+1; the MSB carry falls off the row.
      for (int b = 0; b < int'(WIDTH); b++) begin
        fa = fulladder(rows_i[3*g][b], rows_i[3*g+1][b], rows_i[3*g+2][b]);
        rows_o[2*g][b]   = fa.sum;
        rows_o[2*g+1][b] = cy;
        cy = fa.carry;
      end
    end
    for (int r = 0; r < int'(NUM_LEFT); r++) begin
      rows_o[2*NUM_GRP+r] = rows_i[3*NUM_GRP+r];
    end
  end

endmodule

// File: rtl/compressor_tree_pipe.sv
// Pipelined carry-save reduction tree with valid/ready flow control and flush.
// Define COMPRESSOR_TREE_CPA_EN to resolve sum/carry into result_o; otherwise result_o is 0.
module compressor_tree_pipe
  import compressor_tree_pipe_pkg::*;
#(
  parameter int unsigned NUM_OPS          = 4,
  parameter int unsigned WIDTH_I          = 8,
  parameter int unsigned WIDTH_O          = WIDTH_I + clog2(NUM_OPS),
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter bit          SIGNED           = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_OPS-1:0][WIDTH_I-1:0]  operands_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [WIDTH_O-1:0]               sum_o,
  output logic [WIDTH_O-1:0]               carry_o,
  output logic [WIDTH_O-1:0]               result_o
);

  localparam int unsigned NUM_LVL = num_levels(NUM_OPS);
  localparam int unsigned NUM_STG = (NUM_LVL == 0) ? 1 :
                                    (NUM_LVL + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  logic [NUM_OPS-1:0][WIDTH_O-1:0] ext_ops;
  logic [NUM_STG-1:0]              v_q, v_d, load, ld_en;
  logic [NUM_STG:0]                rdy, up_v;

  always_comb begin
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      if (SIGNED) ext_ops[i] = {{(WIDTH_O-WIDTH_I){operands_i[i][WIDTH_I-1]}}, operands_i[i]};
      else        ext_ops[i] = {{(WIDTH_O-WIDTH_I){1'b0}}, operands_i[i]};
    end
  end

  // Bubble-free ready chain: a stage can take data if empty or if it drains this cycle.
  always_comb begin
    rdy   = '0;
    load  = '0;
    v_d   = v_q;
    up_v  = {v_q, in_valid_i};
    rdy[NUM_STG] = out_ready_i;
    for (int k = int'(NUM_STG) - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
    for (int k = 0; k < int'(NUM_STG); k++) begin
      load[k] = up_v[k] && rdy[k];
      v_d[k]  = load[k] || (v_q[k] && !rdy[k+1]);
    end
    if (flush_i) v_d = '0;
    ld_en = load & {NUM_STG{~flush_i}};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) v_q <= '0;
    else       v_q <= v_d;
  end

  for (genvar k = 0; k < NUM_STG; k++) begin : gen_stg
    localparam int unsigned LO     = k * LEVELS_PER_STAGE;
    localparam int unsigned HI     = ((k + 1) * LEVELS_PER_STAGE < NUM_LVL) ?
                                     (k + 1) * LEVELS_PER_STAGE : NUM_LVL;
    localparam int unsigned NR_IN  = rows_after(NUM_OPS, LO);
    localparam int unsigned NR_OUT = rows_after(NUM_OPS, HI);

    logic [NR_IN-1:0][WIDTH_O-1:0]  in_rows;
    logic [NR_OUT-1:0][WIDTH_O-1:0] rows_d, rows_q;

    if (k == 0) begin : g_src_ops
      assign in_rows = ext_ops;
    end else begin : g_src_prev
      assign in_rows = gen_stg[k-1].rows_q;
    end

    for (genvar j = LO; j < HI; j++) begin : gen_lvl
      logic [rows_after(NUM_OPS, j)-1:0][WIDTH_O-1:0]   lvl_in;
      logic [rows_after(NUM_OPS, j+1)-1:0][WIDTH_O-1:0] lvl_out;

      if (j == LO) begin : g_first
        assign lvl_in = in_rows;
      end else begin : g_chain
        assign lvl_in = gen_lvl[j-1].lvl_out;
      end

      compressor_tree_pipe_csa_level #(
        .N_IN  (rows_after(NUM_OPS, j)),
        .WIDTH (WIDTH_O)
      ) u_lvl (
        .rows_i (lvl_in),
        .rows_o (lvl_out)
      );
    end

    if (HI == LO) begin : g_no_lvl
      assign rows_d = in_rows;
    end else begin : g_lvl_out
      assign rows_d = gen_lvl[HI-1].lvl_out;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         rows_q <= '0;
      else if (ld_en[k]) rows_q <= rows_d;
    end
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = v_q[NUM_STG-1];
  assign sum_o       = gen_stg[NUM_STG-1].rows_q[0];
  assign carry_o     = gen_stg[NUM_STG-1].rows_q[1];

`ifdef COMPRESSOR_TREE_CPA_EN
  assign result_o = sum_o + carry_o;
`else
  assign result_o = '0;
`endif

endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Randomized bench for compressor_tree_pipe: an 8-operand signed deep pipeline
// checked against a queue-based sum model, plus a 4-operand unsigned single-stage tree.
module tb_compressor_tree_pipe;

  localparam int unsigned N   = 8;
  localparam int unsigned WI  = 8;
  localparam int unsigned WO  = 11;
  localparam int unsigned S   = 4;
  localparam int unsigned SN  = 4;
  localparam int unsigned SWO = 10;

  typedef logic [N-1:0][WI-1:0]  ops_t;
  typedef logic [SN-1:0][WI-1:0] sops_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready_o, out_valid_o, out_ready;
  ops_t          operands;
  logic [WO-1:0] sum_o, carry_o, result_o;

  logic           s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  sops_t          s_ops;
  logic [SWO-1:0] s_sum, s_carry, s_result;

  compressor_tree_pipe #(
    .NUM_OPS(N), .WIDTH_I(WI), .LEVELS_PER_STAGE(1), .SIGNED(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .operands_i(operands),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .sum_o(sum_o), .carry_o(carry_o), .result_o(result_o)
  );

  compressor_tree_pipe #(
    .NUM_OPS(SN), .WIDTH_I(WI), .LEVELS_PER_STAGE(2), .SIGNED(1'b0)
  ) u_small (
    .clk_i(clk), .rst_i(rst), .flush_i(s_flush),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .operands_i(s_ops),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .sum_o(s_sum), .carry_o(s_carry), .result_o(s_result)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  int            fires;
  bit            hold_prev;
  bit            saw_stall;
  bit            last_acc;
  logic [WO-1:0] last_out;
  logic [WO-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WO-1:0] ref_sum(input ops_t o);
    int          acc;
    logic [31:0] bits;
    acc = 0;
    for (int i = 0; i < int'(N); i++) acc += int'($signed(o[i]));
    bits = acc;
    return bits[WO-1:0];
  endfunction

  function automatic logic [SWO-1:0] s_ref_sum(input sops_t o);
    int          acc;
    logic [31:0] bits;
    acc = 0;
    for (int i = 0; i < int'(SN); i++) acc += int'(o[i]);
    bits = acc;
    return bits[SWO-1:0];
  endfunction

  function automatic ops_t rand_ops();
    ops_t o;
    for (int i = 0; i < int'(N); i++) o[i] = WI'($urandom);
    return o;
  endfunction

  // One clock of the main DUT: drive, sample, compare against the queue, update the model.
  task automatic cycle(input bit iv, input ops_t ops, input bit ordy, input bit fl);
    logic [WO-1:0] tot;
    @(negedge clk);
    in_valid  = iv;
    operands  = ops;
    out_ready = ordy;
    flush     = fl;
    #1;
    tot = sum_o + carry_o;
    check_eq("in_ready", in_ready_o, (exp_q.size() < S) || ordy);
    if (!in_ready_o) saw_stall = 1'b1;
    if (hold_prev) check_eq("valid_hold", out_valid_o, 1'b1);
    if (exp_q.size() == 0) begin
      check_eq("idle_valid", out_valid_o, 1'b0);
    end else if (out_valid_o) begin
      check_eq("out_data", tot, exp_q[0]);
`ifdef COMPRESSOR_TREE_CPA_EN
      check_eq("result", result_o, exp_q[0]);
`else
      check_eq("result_zero", result_o, 0);
`endif
    end
    hold_prev = out_valid_o && !ordy && !fl;
    last_acc  = iv && in_ready_o && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && ordy) begin
        void'(exp_q.pop_front());
        last_out = tot;
        fires++;
      end
      if (last_acc) exp_q.push_back(ref_sum(ops));
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      budget--;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    ops_t           cur;
    ops_t           o;
    logic [SWO-1:0] s_exp;
    int             n_acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; operands = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_ops = '0;
    fires = 0; hold_prev = 1'b0; saw_stall = 1'b0; last_acc = 1'b0; last_out = '0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_valid", out_valid_o, 1'b0);
    check_eq("rst_sum", sum_o, 0);
    check_eq("rst_carry", carry_o, 0);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_s_valid", s_out_valid, 1'b0);
    check_eq("rst_s_sum", s_sum, 0);
    @(negedge clk);
    rst = 1'b0;

    // Small unsigned tree: all-ones bundle, then back-to-back randoms
    @(negedge clk);
    for (int i = 0; i < int'(SN); i++) s_ops[i] = 8'hFF;
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    #1;
    check_eq("s_in_ready", s_in_ready, 1'b1);
    s_exp = s_ref_sum(s_ops);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int b = 0; b < int'(SN); b++) s_ops[b] = WI'($urandom);
      #1;
      check_eq("s_valid", s_out_valid, 1'b1);
      check_eq("s_data", SWO'(s_sum + s_carry), s_exp);
      if (i == 0) check_eq("s_ff_sum", SWO'(s_sum + s_carry), 1020);
      s_exp = s_ref_sum(s_ops);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    check_eq("s_last", SWO'(s_sum + s_carry), s_exp);
    @(negedge clk);
    #1;
    check_eq("s_idle", s_out_valid, 1'b0);

    // Main tree: all -128, latency of four stages
    for (int i = 0; i < int'(N); i++) o[i] = 8'h80;
    cycle(1'b1, o, 1'b1, 1'b0);
    for (int i = 1; i < int'(S); i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("lat_early", out_valid_o, 1'b0);
    end
    fires = 0;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("lat_at_s", out_valid_o, 1'b1);
    check_eq("neg128_fire", fires, 1);
    check_eq("neg128_sum", last_out, 11'h400);
`ifdef COMPRESSOR_TREE_CPA_EN
    check_eq("neg128_result", result_o, 11'h400);
`endif
    drain();

    // Back-to-back random bundles at full throughput
    fires = 0;
    for (int i = 0; i < 20; i++) cycle(1'b1, rand_ops(), 1'b1, 1'b0);
    drain();
    check_eq("b2b_count", fires, 20);

    // Backpressure with a continuous, holding source
    fires = 0; n_acc = 0; saw_stall = 1'b0;
    cur = rand_ops();
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1, cur, !(c >= 2 && c < 8), 1'b0);
      if (last_acc) begin
        n_acc++;
        cur = rand_ops();
      end
    end
    drain();
    check_eq("bp_stalled", saw_stall, 1'b1);
    check_eq("bp_count", fires, n_acc);

    // Flush with three bundles in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_ops(), 1'b0, 1'b0);
    cycle(1'b1, rand_ops(), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("flush_valid", out_valid_o, 1'b0);
    fires = 0;
    o = '0;
    o[0] = 8'd1; o[1] = 8'd2; o[2] = 8'd3; o[3] = 8'd4;
    cycle(1'b1, o, 1'b1, 1'b0);
    drain();
    check_eq("flush_count", fires, 1);
    check_eq("flush_sum", last_out, 10);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_ops(), 1'b1, 1'b0);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", out_valid_o, 1'b0);
    check_eq("arst_sum", sum_o, 0);
    check_eq("arst_carry", carry_o, 0);
    check_eq("arst_result", result_o, 0);
    check_eq("arst_ready", in_ready_o, 1'b1);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fires = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, rand_ops(), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    check_eq("post_rst_nonzero", (fires > 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
